ray_aabb_scheduler: RTL and testbench
=====================================

// Module: ray_aabb_scheduler
// PURPOSE
//  Upstream feeder and downstream collector around the Ray_AABB_11_6 intersection pipeline.
//  Accepts one ray: origin, reciprocal direction and direction signs.
//  Streams NUM_BOXES boxes from an external box memory into the pipeline, one per cycle.
//  The pipeline has no valid or stall signals. This block tracks validity and box index
//  alongside it, assembles a per-ray hit mask, and returns the mask over a valid/ready handshake.
// PARAMETERS
//  WE        11   exponent width of the FloPoCo float format
//  WF        6    fraction width
//  FW        20   float word width = WE+WF+3 (2 exception bits, 1 sign bit)
//  NUM_BOXES 8    boxes tested per ray, >=1
//  AW        3    box address width = clog2(NUM_BOXES), minimum 1
//  LATENCY   38   pipeline cycles from operands presented to hit_miss valid
// PORTS
//  clk          in  1     clock; all state changes on the rising edge
//  rst          in  1     asynchronous, active-low reset
//  ray_valid    in  1     ray_* inputs are valid
//  ray_ready    out 1     block can accept a ray
//  ray_org      in  3*FW  origin {z,y,x}
//  ray_div      in  3*FW  reciprocal direction {z,y,x}
//  ray_sign     in  3     direction sign bits {z,y,x}
//  box_rd_addr  out AW    box memory read address
//  box_rd_data  in  6*FW  {zmax,ymax,xmax,zmin,ymin,xmin}; valid 1 cycle after the address
//  x0,y0,z0     out FW    origin to the pipeline
//  x1,y1,z1     out FW    box minimum corner to the pipeline
//  x2,y2,z2     out FW    box maximum corner to the pipeline
//  divx,divy,divz out FW  reciprocal direction to the pipeline
//  x,y,z        out 1     sign bits to the pipeline
//  op_valid     out 1     pipeline operands valid this cycle (debug/trace)
//  hit_miss     in  1     pipeline result
//  mask_valid   out 1     result available
//  mask_ready   in  1     consumer accepts the result
//  hit_mask     out NUM_BOXES  bit k = 1 if box k was hit
//  hit_count    out AW+1  population count of hit_mask
// BEHAVIOUR
//  Reset (rst=0, asynchronous):
//   - state=IDLE.
//   - All outputs 0, except ray_ready=1.
//   - Valid/index delay line cleared.
//  FSM:
//   IDLE  -> ISSUE on ray_valid & ray_ready.
//            Latch ray_org, ray_div, ray_sign. Clear hit_mask and hit_count.
//   ISSUE -> drive box_rd_addr = 0..NUM_BOXES-1, one per cycle.
//            After the last address, go to DRAIN.
//   DRAIN -> wait until the delay line is empty and the last result is captured, then go to DONE.
//   DONE  -> hold mask_valid=1 until mask_ready.
//            On mask_valid & mask_ready go to IDLE. ray_ready=1 in the same cycle.
//  ray_ready is 1 only in IDLE. Rays never overlap.
//  Timing, with cycle 0 = ray handshake:
//   - Cycle k+1: box_rd_addr = k.
//   - Cycle k+2: operands for box k are registered on x0..z, and op_valid=1.
//   - Origin, div and sign outputs stay constant for the whole ray.
//   - Cycle k+2+LATENCY: hit_miss is sampled and written to hit_mask[k]; hit_count increments if 1.
//  Delay line: LATENCY entries of {valid, index}. It shifts every cycle and never stalls.
//   hit_miss is ignored on cycles whose tap entry is invalid.
//  mask_valid rises in cycle NUM_BOXES+LATENCY+2.
//   This is 48 for the defaults.
//  mask_ready has no effect on the pipeline. Results are always captured.
//   The backlog is at most one completed ray (held in DONE).
//  Boundary cases:
//   - NUM_BOXES=1: ISSUE lasts exactly 1 cycle.
//   - ray_valid asserted outside IDLE: ignored; the ray is not consumed.
//   - mask_ready high before mask_valid: no effect.
//   - rst asserted mid-ray: in-flight results are discarded. The first post-reset hit_miss
//     samples are ignored because the delay line is cleared.
//   - hit_count is saturation-free: the maximum NUM_BOXES fits in AW+1 bits.
// TESTING
//  T1: ray org=(0,0,0), 8 boxes with box 3 and box 6 enclosing the ray
//      -> mask_valid at cycle 48, hit_mask=8'b0100_1000, hit_count=2.
//  T2: mask_ready held low 20 cycles after mask_valid
//      -> mask and count are stable, ray_ready=0, and a new ray_valid is not accepted.
//  T3: back-to-back rays with ray_valid constantly 1 and mask_ready=1
//      -> second handshake occurs the cycle after the first mask handshake; no mask bits leak between rays.
//  T4: rst pulsed low in cycle 20 of a ray, then a new ray with no hits
//      -> all outputs 0 during reset, and the new mask is 8'h00 despite stale hit_miss=1 from the pipe.
//  T5: NUM_BOXES=1, single box hit
//      -> box_rd_addr=0 in cycle 1, op_valid only in cycle 2, mask_valid at cycle 41, hit_mask=1.
//  T6: all 8 boxes hit
//      -> hit_mask=8'hFF, hit_count=8; op_valid is high for exactly 8 consecutive cycles (2..9).

Source files
------------

// File: rtl/ray_aabb_scheduler.sv
// Purpose: feeds one ray plus NUM_BOXES boxes into the Ray_AABB pipeline and collects a per-ray hit mask.
// Latency: box k enters the pipe in cycle k+2; the mask is valid in cycle NUM_BOXES+LATENCY+2 after the ray handshake.
// Backpressure: one ray in flight; the pipeline never stalls; the finished mask is held until mask_ready.
module ray_aabb_scheduler #(
   parameter int WE        = 11,
   parameter int WF        = 6,
   parameter int FW        = WE + WF + 3,
   parameter int NUM_BOXES = 8,
   parameter int AW        = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1,
   parameter int LATENCY   = 38
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ray_valid,
   output logic                 ray_ready,
   input  logic [3*FW-1:0]      ray_org,
   input  logic [3*FW-1:0]      ray_div,
   input  logic [2:0]           ray_sign,
   output logic [AW-1:0]        box_rd_addr,
   input  logic [6*FW-1:0]      box_rd_data,
   output logic [FW-1:0]        x0,
   output logic [FW-1:0]        y0,
   output logic [FW-1:0]        z0,
   output logic [FW-1:0]        x1,
   output logic [FW-1:0]        y1,
   output logic [FW-1:0]        z1,
   output logic [FW-1:0]        x2,
   output logic [FW-1:0]        y2,
   output logic [FW-1:0]        z2,
   output logic [FW-1:0]        divx,
   output logic [FW-1:0]        divy,
   output logic [FW-1:0]        divz,
   output logic                 x,
   output logic                 y,
   output logic                 z,
   output logic                 op_valid,
   input  logic                 hit_miss,
   output logic                 mask_valid,
   input  logic                 mask_ready,
   output logic [NUM_BOXES-1:0] hit_mask,
   output logic [AW:0]          hit_count
);

   localparam logic [AW-1:0] LAST = AW'(NUM_BOXES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t          state;
   logic [3*FW-1:0] org_q;
   logic [3*FW-1:0] div_q;
   logic [2:0]      sign_q;
   logic [AW-1:0]   op_idx;

   // {valid, index} shadow of the pipeline; entry LATENCY-1 lines up with hit_miss
   logic            dl_vld [LATENCY];
   logic [AW-1:0]   dl_idx [LATENCY];
   logic            tap_vld;
   logic [AW-1:0]   tap_idx;

   assign tap_vld = dl_vld[LATENCY-1];
   assign tap_idx = dl_idx[LATENCY-1];

   // Ray operands are latched at the handshake and held for the whole ray
   assign x0   = org_q[FW-1:0];
   assign y0   = org_q[2*FW-1:FW];
   assign z0   = org_q[3*FW-1:2*FW];
   assign divx = div_q[FW-1:0];
   assign divy = div_q[2*FW-1:FW];
   assign divz = div_q[3*FW-1:2*FW];
   assign x    = sign_q[0];
   assign y    = sign_q[1];
   assign z    = sign_q[2];

   // The box memory output register already aligns box k with op_valid in cycle k+2;
   // gating keeps the corner operands quiet outside valid cycles and during reset.
   assign x1 = op_valid ? box_rd_data[FW-1:0]      : '0;
   assign y1 = op_valid ? box_rd_data[2*FW-1:FW]   : '0;
   assign z1 = op_valid ? box_rd_data[3*FW-1:2*FW] : '0;
   assign x2 = op_valid ? box_rd_data[4*FW-1:3*FW] : '0;
   assign y2 = op_valid ? box_rd_data[5*FW-1:4*FW] : '0;
   assign z2 = op_valid ? box_rd_data[6*FW-1:5*FW] : '0;

   // Delay line shifts every cycle so validity tracks the stall-free pipeline exactly
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < LATENCY; i++) begin
            dl_vld[i] <= 1'b0;
            dl_idx[i] <= '0;
         end
      end else begin
         dl_vld[0] <= op_valid;
         dl_idx[0] <= op_idx;
         for (int i = 1; i < LATENCY; i++) begin
            dl_vld[i] <= dl_vld[i-1];
            dl_idx[i] <= dl_idx[i-1];
         end
      end
   end

   // Control FSM with registered outputs: issue addresses, capture results, hold the mask
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         ray_ready   <= 1'b1;
         box_rd_addr <= '0;
         op_valid    <= 1'b0;
         op_idx      <= '0;
         org_q       <= '0;
         div_q       <= '0;
         sign_q      <= '0;
         mask_valid  <= 1'b0;
         hit_mask    <= '0;
         hit_count   <= '0;
      end else begin
         op_valid <= (state == ISSUE);
         op_idx   <= box_rd_addr;

         if (tap_vld && hit_miss) begin
            for (int k = 0; k < NUM_BOXES; k++) begin
               if (tap_idx == AW'(k)) hit_mask[k] <= 1'b1;
            end
            hit_count <= hit_count + (AW+1)'(1);
         end

         case (state)
            IDLE: begin
               if (ray_valid) begin
                  org_q       <= ray_org;
                  div_q       <= ray_div;
                  sign_q      <= ray_sign;
                  hit_mask    <= '0;
                  hit_count   <= '0;
                  box_rd_addr <= '0;
                  ray_ready   <= 1'b0;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (box_rd_addr == LAST) begin
                  box_rd_addr <= '0;
                  state       <= DRAIN;
               end else begin
                  box_rd_addr <= box_rd_addr + AW'(1);
               end
            end
            DRAIN: begin
               // Rays never overlap, so the last index at the tap means the line is otherwise empty
               if (tap_vld && tap_idx == LAST) begin
                  mask_valid <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               if (mask_ready) begin
                  mask_valid <= 1'b0;
                  ray_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ray_aabb_scheduler.sv
// Purpose: self-checking bench for ray_aabb_scheduler with a box memory and a stand-in pipeline model.
// Latency: the stand-in pipe returns an enclosure test LATENCY cycles after op_valid, and 1 on idle slots.
// Backpressure: mask_ready is driven per test; expected masks queue at ray issue and retire at mask handshake.
module tb_ray_aabb_scheduler;

   localparam int FW  = 20;
   localparam int NB  = 8;
   localparam int LAT = 38;
   localparam logic [3*FW-1:0] DIV  = {20'h1A2B3, 20'h0C0DE, 20'h7F00F};
   localparam logic [2:0]      SIGN = 3'b101;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // ---------------- DUT A: 8 boxes ----------------
   logic a_ray_valid = 1'b0, a_ray_ready, a_mask_ready = 1'b1, a_mask_valid;
   logic [3*FW-1:0] a_ray_org = '0;
   logic [3*FW-1:0] a_ray_div = DIV;
   logic [2:0]      a_ray_sign = SIGN;
   logic [2:0]      a_box_rd_addr;
   logic [6*FW-1:0] a_box_rd_data;
   logic [FW-1:0]   a_x0, a_y0, a_z0, a_x1, a_y1, a_z1, a_x2, a_y2, a_z2, a_divx, a_divy, a_divz;
   logic            a_x, a_y, a_z, a_op_valid, a_hit_miss;
   logic [NB-1:0]   a_hit_mask;
   logic [3:0]      a_hit_count;

   ray_aabb_scheduler #(.NUM_BOXES(NB), .LATENCY(LAT)) dut_a (
      .clk(clk), .rst(rst), .ray_valid(a_ray_valid), .ray_ready(a_ray_ready),
      .ray_org(a_ray_org), .ray_div(a_ray_div), .ray_sign(a_ray_sign),
      .box_rd_addr(a_box_rd_addr), .box_rd_data(a_box_rd_data),
      .x0(a_x0), .y0(a_y0), .z0(a_z0), .x1(a_x1), .y1(a_y1), .z1(a_z1),
      .x2(a_x2), .y2(a_y2), .z2(a_z2), .divx(a_divx), .divy(a_divy), .divz(a_divz),
      .x(a_x), .y(a_y), .z(a_z), .op_valid(a_op_valid), .hit_miss(a_hit_miss),
      .mask_valid(a_mask_valid), .mask_ready(a_mask_ready),
      .hit_mask(a_hit_mask), .hit_count(a_hit_count));

   // ---------------- DUT B: single box ----------------
   logic b_ray_valid = 1'b0, b_ray_ready, b_mask_ready = 1'b1, b_mask_valid;
   logic [3*FW-1:0] b_ray_org = '0;
   logic [3*FW-1:0] b_ray_div = DIV;
   logic [2:0]      b_ray_sign = SIGN;
   logic [0:0]      b_box_rd_addr;
   logic [6*FW-1:0] b_box_rd_data;
   logic [FW-1:0]   b_x0, b_y0, b_z0, b_x1, b_y1, b_z1, b_x2, b_y2, b_z2, b_divx, b_divy, b_divz;
   logic            b_x, b_y, b_z, b_op_valid, b_hit_miss;
   logic [0:0]      b_hit_mask;
   logic [1:0]      b_hit_count;

   ray_aabb_scheduler #(.NUM_BOXES(1), .LATENCY(LAT)) dut_b (
      .clk(clk), .rst(rst), .ray_valid(b_ray_valid), .ray_ready(b_ray_ready),
      .ray_org(b_ray_org), .ray_div(b_ray_div), .ray_sign(b_ray_sign),
      .box_rd_addr(b_box_rd_addr), .box_rd_data(b_box_rd_data),
      .x0(b_x0), .y0(b_y0), .z0(b_z0), .x1(b_x1), .y1(b_y1), .z1(b_z1),
      .x2(b_x2), .y2(b_y2), .z2(b_z2), .divx(b_divx), .divy(b_divy), .divz(b_divz),
      .x(b_x), .y(b_y), .z(b_z), .op_valid(b_op_valid), .hit_miss(b_hit_miss),
      .mask_valid(b_mask_valid), .mask_ready(b_mask_ready),
      .hit_mask(b_hit_mask), .hit_count(b_hit_count));

   // ---------------- box memories and stand-in pipelines ----------------
   logic [6*FW-1:0] mem_a [NB];
   localparam logic [6*FW-1:0] BOX_B = {20'd5, 20'd5, 20'd5, 20'd0, 20'd0, 20'd0};
   logic [3*FW-1:0] cur_org = '0;
   logic [3*FW-1:0] cur_div = '0;
   logic [2:0]      cur_sign = '0;
   logic [LAT-1:0]  pipe_a = '1;
   logic [LAT-1:0]  pipe_b = '1;

   function automatic logic inside_rng(input logic [FW-1:0] o, input logic [FW-1:0] lo, input logic [FW-1:0] hi);
      return (o >= lo) && (o <= hi);
   endfunction

   always @(posedge clk) begin
      cyc           <= cyc + 1;
      a_box_rd_data <= mem_a[a_box_rd_addr];
      b_box_rd_data <= (b_box_rd_addr == 1'b0) ? BOX_B : '0;
      pipe_a <= {pipe_a[LAT-2:0], a_op_valid ?
                 (inside_rng(a_x0, a_x1, a_x2) && inside_rng(a_y0, a_y1, a_y2) && inside_rng(a_z0, a_z1, a_z2) &&
                  {a_z0, a_y0, a_x0} == cur_org && {a_divz, a_divy, a_divx} == cur_div &&
                  {a_z, a_y, a_x} == cur_sign) : 1'b1};
      pipe_b <= {pipe_b[LAT-2:0], b_op_valid ?
                 (inside_rng(b_x0, b_x1, b_x2) && inside_rng(b_y0, b_y1, b_y2) && inside_rng(b_z0, b_z1, b_z2) &&
                  {b_z0, b_y0, b_x0} == b_ray_org && {b_divz, b_divy, b_divx} == b_ray_div &&
                  {b_z, b_y, b_x} == b_ray_sign) : 1'b1};
   end
   assign a_hit_miss = pipe_a[LAT-1];
   assign b_hit_miss = pipe_b[LAT-1];

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct { logic [7:0] mask; logic [3:0] cnt; } sb_t;
   sb_t sb [$];

   int hs_cnt = 0, hs_cyc = 0, mhs_cnt = 0, mhs_cyc = 0;
   int opv_first = 0, opv_last = 0, opv_cnt = 0, mv_cyc = 0;
   bit mv_seen = 0;

   // Monitor for DUT A: per-ray timing stats and scoreboard retirement at the mask handshake
   always @(negedge clk) begin
      if (rst) begin
         if (a_op_valid) begin
            if (opv_cnt == 0) opv_first = cyc - hs_cyc;
            opv_last = cyc - hs_cyc;
            opv_cnt++;
         end
         if (a_mask_valid && !mv_seen) begin
            mv_seen = 1;
            mv_cyc  = cyc - hs_cyc;
         end
         if (a_mask_valid && a_mask_ready) begin
            mhs_cnt++;
            mhs_cyc = cyc;
            if (sb.size() == 0) chk("sb_unexpected_mask", 64'(a_hit_mask), 64'hDEAD);
            else begin
               sb_t e;
               e = sb.pop_front();
               chk("mask", 64'(a_hit_mask), 64'(e.mask));
               chk("count", 64'(a_hit_count), 64'(e.cnt));
            end
         end
         if (a_ray_valid && a_ray_ready) begin
            hs_cnt++;
            hs_cyc   = cyc;
            opv_cnt  = 0;
            mv_seen  = 0;
            cur_org  = a_ray_org;
            cur_div  = a_ray_div;
            cur_sign = a_ray_sign;
         end
      end
   end

   task automatic wait_hs(input int target);
      int t = 0;
      while (hs_cnt < target && t < 400) begin @(negedge clk); t++; end
      if (hs_cnt < target) chk("ray_handshake_timeout", 64'(hs_cnt), 64'(target));
   endtask

   task automatic wait_mhs(input int target);
      int t = 0;
      while (mhs_cnt < target && t < 400) begin @(negedge clk); t++; end
      if (mhs_cnt < target) chk("mask_handshake_timeout", 64'(mhs_cnt), 64'(target));
   endtask

   task automatic wait_mv();
      int t = 0;
      while (!mv_seen && t < 400) begin @(negedge clk); t++; end
      if (!mv_seen) chk("mask_valid_timeout", 64'(mv_seen), 64'd1);
   endtask

   function automatic logic [3*FW-1:0] mk(input int xx, input int yy, input int zz);
      return {FW'(zz), FW'(yy), FW'(xx)};
   endfunction

   // Box k encloses the region x,y,z in [0,5] when its bit is set, else x in [10,20], y,z in [0,5]
   task automatic set_boxes(input logic [7:0] encl);
      for (int k = 0; k < NB; k++)
         mem_a[k] = {20'd5, 20'd5, encl[k] ? 20'd5 : 20'd20, 20'd0, 20'd0, encl[k] ? 20'd0 : 20'd10};
   endtask

   task automatic run_vec(input logic [3*FW-1:0] org, input logic [7:0] encl,
                          input logic [7:0] exp_mask, input logic [3:0] exp_cnt);
      int h0, m0;
      sb_t e;
      @(posedge clk); #1;
      set_boxes(encl);
      a_ray_org    = org;
      a_mask_ready = 1'b1;
      e.mask = exp_mask; e.cnt = exp_cnt;
      sb.push_back(e);
      h0 = hs_cnt; m0 = mhs_cnt;
      a_ray_valid = 1'b1;
      wait_hs(h0 + 1);
      @(posedge clk); #1;
      a_ray_valid = 1'b0;
      wait_mhs(m0 + 1);
      chk("mask_valid_cycle", 64'(mv_cyc), 64'(NB + LAT + 2));
      chk("op_valid_first", 64'(opv_first), 64'd2);
      chk("op_valid_last", 64'(opv_last), 64'(NB + 1));
      chk("op_valid_count", 64'(opv_cnt), 64'(NB));
   endtask

   typedef struct { logic [3*FW-1:0] org; logic [7:0] encl; logic [7:0] exp_mask; logic [3:0] exp_cnt; } vec_t;
   vec_t vt [7];

   initial begin
      int h0, m0, m1, b_opv, b_first, b_mcyc;
      bit b_seen;
      sb_t e;

      vt[0] = '{mk(0, 0, 0),  8'h48, 8'h48, 4'd2};   // boxes 3 and 6 enclose the origin
      vt[1] = '{mk(0, 0, 0),  8'hFF, 8'hFF, 4'd8};   // every box hit
      vt[2] = '{mk(0, 0, 0),  8'h00, 8'h00, 4'd0};
      vt[3] = '{mk(3, 4, 5),  8'hA5, 8'hA5, 4'd4};
      vt[4] = '{mk(30, 0, 0), 8'hFF, 8'h00, 4'd0};   // origin outside every box
      vt[5] = '{mk(5, 0, 5),  8'h81, 8'h81, 4'd2};   // origin on the max faces
      vt[6] = '{mk(10, 0, 0), 8'h0F, 8'hF0, 4'd4};   // only the [10,20] boxes contain it

      // Reset state
      @(negedge clk);
      chk("rst_ray_ready_a", 64'(a_ray_ready), 64'd1);
      chk("rst_outputs_a", 64'(|{a_box_rd_addr, a_x0, a_y0, a_z0, a_x1, a_y1, a_z1, a_x2, a_y2, a_z2,
                                 a_divx, a_divy, a_divz, a_x, a_y, a_z, a_op_valid, a_mask_valid,
                                 a_hit_mask, a_hit_count}), 64'd0);
      chk("rst_ray_ready_b", 64'(b_ray_ready), 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;

      // Table-driven rays
      for (int i = 0; i < 7; i++) run_vec(vt[i].org, vt[i].encl, vt[i].exp_mask, vt[i].exp_cnt);

      // Held mask: consumer stalls 20 cycles, a competing ray must not be taken
      @(posedge clk); #1;
      set_boxes(8'h48);
      a_ray_org = mk(0, 0, 0);
      a_mask_ready = 1'b0;
      e.mask = 8'h48; e.cnt = 4'd2;
      sb.push_back(e);
      h0 = hs_cnt;
      a_ray_valid = 1'b1;
      wait_hs(h0 + 1);
      @(posedge clk); #1;
      a_ray_valid = 1'b0;
      wait_mv();
      @(posedge clk); #1;
      a_ray_valid = 1'b1;
      repeat (20) begin
         @(negedge clk);
         chk("hold_mask", 64'(a_hit_mask), 64'h48);
         chk("hold_count", 64'(a_hit_count), 64'd2);
         chk("hold_ray_ready", 64'(a_ray_ready), 64'd0);
         chk("hold_mask_valid", 64'(a_mask_valid), 64'd1);
      end
      chk("hold_no_accept", 64'(hs_cnt), 64'(h0 + 1));
      @(posedge clk); #1;
      a_ray_valid = 1'b0;
      m0 = mhs_cnt;
      a_mask_ready = 1'b1;
      wait_mhs(m0 + 1);

      // Back-to-back rays: all hits, then an origin outside every box
      @(posedge clk); #1;
      set_boxes(8'hFF);
      a_ray_org = mk(0, 0, 0);
      e.mask = 8'hFF; e.cnt = 4'd8; sb.push_back(e);
      e.mask = 8'h00; e.cnt = 4'd0; sb.push_back(e);
      h0 = hs_cnt; m0 = mhs_cnt;
      a_ray_valid = 1'b1;
      wait_hs(h0 + 1);
      @(posedge clk); #1;
      a_ray_org = mk(30, 0, 0);
      wait_mhs(m0 + 1);
      m1 = mhs_cyc;
      wait_hs(h0 + 2);
      chk("b2b_handshake_cycle", 64'(hs_cyc), 64'(m1 + 1));
      @(posedge clk); #1;
      a_ray_valid = 1'b0;
      wait_mhs(m0 + 2);
      chk("b2b_mask_valid_cycle", 64'(mv_cyc), 64'(NB + LAT + 2));

      // Reset in the middle of a ray, then a ray with no hits while the pipe still returns 1s
      @(posedge clk); #1;
      set_boxes(8'hFF);
      a_ray_org = mk(0, 0, 0);
      h0 = hs_cnt;
      a_ray_valid = 1'b1;
      wait_hs(h0 + 1);
      @(posedge clk); #1;
      a_ray_valid = 1'b0;
      repeat (18) @(posedge clk);
      #2 rst = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("midrst_ray_ready", 64'(a_ray_ready), 64'd1);
         chk("midrst_outputs", 64'(|{a_box_rd_addr, a_x0, a_y0, a_z0, a_x1, a_y1, a_z1, a_x2, a_y2, a_z2,
                                     a_divx, a_divy, a_divz, a_x, a_y, a_z, a_op_valid, a_mask_valid,
                                     a_hit_mask, a_hit_count}), 64'd0);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      sb.delete();
      run_vec(mk(0, 0, 0), 8'h00, 8'h00, 4'd0);

      // Single-box instance
      @(posedge clk); #1;
      b_ray_valid = 1'b1;
      @(negedge clk);
      chk("b_ray_ready", 64'(b_ray_ready), 64'd1);
      @(posedge clk); #1;
      b_ray_valid = 1'b0;
      b_opv = 0; b_first = 0; b_mcyc = 0; b_seen = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == 1) begin
            chk("b_addr_cycle1", 64'(b_box_rd_addr), 64'd0);
            chk("b_no_op_cycle1", 64'(b_op_valid), 64'd0);
         end
         if (b_op_valid) begin
            if (b_opv == 0) b_first = c;
            b_opv++;
         end
         if (b_mask_valid && !b_seen) begin
            b_seen = 1;
            b_mcyc = c;
            chk("b_mask", 64'(b_hit_mask), 64'd1);
            chk("b_count", 64'(b_hit_count), 64'd1);
         end
      end
      chk("b_mask_seen", 64'(b_seen), 64'd1);
      chk("b_mask_valid_cycle", 64'(b_mcyc), 64'(1 + LAT + 2));
      chk("b_op_valid_first", 64'(b_first), 64'd2);
      chk("b_op_valid_count", 64'(b_opv), 64'd1);

      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
      $fatal(1, "watchdog expired");
   end

endmodule
